// File: rtl/icache_l1.sv
// rtl/icache_l1.sv - S-set, E-way, B-byte-block L1 instruction cache with LRU and beat refill
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   PCF                    fetch address {tag, set index, byte offset}
//   RepReady, RepWord      refill beat valid / 64-bit refill beat (low word = lower address)
//   PCSrcReg               non-zero aborts an in-flight refill (fetch redirect)
//   BranchOpE              unused by the cache
//   InstrF, InstrMissF     combinational fetch word / miss flag
//   InstrCacheRepActive    refill in progress
module icache_l1 #(
  parameter int S = 32,
  parameter int E = 4,
  parameter int B = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        RepReady,
  input  logic [63:0] RepWord,
  input  logic [1:0]  PCSrcReg,
  input  logic [1:0]  BranchOpE,
  output logic [31:0] InstrF,
  output logic        InstrMissF,
  output logic        InstrCacheRepActive
);

  localparam int SB = $clog2(S);
  localparam int BB = $clog2(B);
  localparam int TW = 32 - SB - BB;
  localparam int NB = B / 8;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam int WW = $clog2(E);

  // Storage arrays: data and tags are never reset, only valid bits and ages.
  logic [63:0]   data_mem [S][E][NB];
  logic [TW-1:0] tag_mem  [S][E];

  logic [E-1:0]  valid_q [S];
  logic [E-1:0]  valid_d [S];
  logic [WW-1:0] age_q   [S][E];
  logic [WW-1:0] age_d   [S][E];
  logic [KW-1:0] k_q, k_d;
  logic [WW-1:0] victim_q, victim_d;

  logic [SB-1:0] set_idx;
  logic [TW-1:0] pc_tag;
  logic [KW-1:0] rd_beat;
  logic          hit;
  logic [WW-1:0] hit_way;
  logic [WW-1:0] free_way;
  logic          free_found;
  logic [WW-1:0] lru_way;
  logic [WW-1:0] max_age;
  logic [WW-1:0] refill_way;
  logic          abort;
  logic          beat_wr;
  logic          last_beat;
  logic          touch_en;
  logic [WW-1:0] touch_way;
  logic [WW-1:0] old_age;
  logic [63:0]   rd_dword;

  logic unused_branch_op;
  assign unused_branch_op = ^BranchOpE;

  assign set_idx = PCF[SB+BB-1:BB];
  assign pc_tag  = PCF[31:SB+BB];
  assign rd_beat = KW'(PCF[BB-1:0] >> 3);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < E; w++) begin
      if (valid_q[set_idx][w] && (tag_mem[set_idx][w] == pc_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  assign rd_dword   = data_mem[set_idx][hit_way][rd_beat];
  assign InstrMissF = ~hit;
  assign InstrF     = hit ? (PCF[2] ? rd_dword[63:32] : rd_dword[31:0]) : 32'h0;

  // Victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    lru_way    = '0;
    max_age    = '0;
    for (int w = 0; w < E; w++) begin
      if (!free_found && !valid_q[set_idx][w]) begin
        free_found = 1'b1;
        free_way   = WW'(w);
      end
      if (age_q[set_idx][w] >= max_age) begin
        max_age = age_q[set_idx][w];
        lru_way = WW'(w);
      end
    end
  end

  // The victim is chosen on the first beat and latched for the remaining beats.
  assign refill_way = (k_q == '0) ? (free_found ? free_way : lru_way) : victim_q;
  assign abort      = (PCSrcReg != 2'b00) && (k_q != '0);
  assign beat_wr    = InstrMissF && RepReady && !abort;
  assign last_beat  = (k_q == KW'(NB - 1));

  assign InstrCacheRepActive = (k_q != '0) || (InstrMissF && RepReady);

  always_comb begin
    valid_d   = valid_q;
    age_d     = age_q;
    k_d       = k_q;
    victim_d  = victim_q;
    touch_en  = 1'b0;
    touch_way = hit_way;
    if (abort) begin
      k_d = '0;
    end else if (beat_wr) begin
      victim_d = refill_way;
      if (last_beat) begin
        k_d                         = '0;
        valid_d[set_idx][refill_way] = 1'b1;
        touch_en                    = 1'b1;
        touch_way                   = refill_way;
      end else begin
        // Keep the block invalid while it is partially written.
        k_d                         = k_q + KW'(1);
        valid_d[set_idx][refill_way] = 1'b0;
      end
    end
    if (hit) begin
      touch_en  = 1'b1;
      touch_way = hit_way;
    end
    old_age = age_q[set_idx][touch_way];
    if (touch_en) begin
      for (int w = 0; w < E; w++) begin
        if (WW'(w) == touch_way) begin
          age_d[set_idx][w] = '0;
        end else if (age_q[set_idx][w] < old_age) begin
          age_d[set_idx][w] = age_q[set_idx][w] + WW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < S; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < E; w++) begin
          age_q[s][w] <= WW'(w);
        end
      end
      k_q      <= '0;
      victim_q <= '0;
    end else begin
      valid_q  <= valid_d;
      age_q    <= age_d;
      k_q      <= k_d;
      victim_q <= victim_d;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_wr) begin
      data_mem[set_idx][refill_way][k_q] <= RepWord;
      if (last_beat) begin
        tag_mem[set_idx][refill_way] <= pc_tag;
      end
    end
  end

endmodule

// File: tb/tb_icache_l1.sv
// tb/tb_icache_l1.sv - self-checking bench for icache_l1
module tb_icache_l1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        RepReady;
  logic [63:0] RepWord;
  logic [1:0]  PCSrcReg;
  logic [1:0]  BranchOpE;
  logic [31:0] InstrF;
  logic        InstrMissF;
  logic        InstrCacheRepActive;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  icache_l1 dut (
    .clk(clk),
    .reset(reset),
    .PCF(PCF),
    .RepReady(RepReady),
    .RepWord(RepWord),
    .PCSrcReg(PCSrcReg),
    .BranchOpE(BranchOpE),
    .InstrF(InstrF),
    .InstrMissF(InstrMissF),
    .InstrCacheRepActive(InstrCacheRepActive)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pc_of(input int tg, input int set, input int off);
    logic [20:0] t;
    logic [4:0]  s;
    logic [5:0]  o;
    t = 21'(tg);
    s = 5'(set);
    o = 6'(off);
    return {t, s, o};
  endfunction

  // mode 0: lo=k, hi=k^2 ; mode 1: lo=(i*1111)k^2+i^2, hi=(i*2222)k^2+i^2
  function automatic logic [63:0] beat(input int mode, input int i, input int k);
    logic [31:0] lo, hi;
    if (mode == 0) begin
      lo = 32'(k);
      hi = 32'(k * k);
    end else begin
      lo = 32'(i * 1111 * k * k + i * i);
      hi = 32'(i * 2222 * k * k + i * i);
    end
    return {hi, lo};
  endfunction

  function automatic logic [31:0] word_exp(input int mode, input int i, input int j);
    logic [63:0] b;
    b = beat(mode, i, j / 2);
    return (j % 2 == 1) ? b[63:32] : b[31:0];
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    tests++;
    assert (obs === e.exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
    end
  endtask

  // Called at a negedge; compares combinational outputs, then advances one cycle.
  task automatic check_word(input string tag, input logic [31:0] pc,
                            input logic exp_miss, input logic [31:0] exp_instr);
    PCF      = pc;
    RepReady = 1'b0;
    #1;
    push_exp({tag, " miss"}, 32'(exp_miss));
    pop_cmp(32'(InstrMissF));
    push_exp({tag, " instr"}, exp_instr);
    pop_cmp(InstrF);
    @(negedge clk);
  endtask

  task automatic check_active(input string tag, input logic exp_act);
    #1;
    push_exp({tag, " active"}, 32'(exp_act));
    pop_cmp(32'(InstrCacheRepActive));
  endtask

  task automatic check_block(input string tag, input int tg, input int set,
                             input int mode, input int i);
    for (int j = 0; j < 16; j++) begin
      check_word(tag, pc_of(tg, set, j * 4), 1'b0, word_exp(mode, i, j));
    end
  endtask

  // Drives beats first..last-1 of a refill starting at a negedge.
  task automatic beats(input logic [31:0] pc, input int mode, input int i,
                       input int first, input int last);
    PCF      = pc;
    RepReady = 1'b1;
    for (int k = first; k < last; k++) begin
      RepWord = beat(mode, i, k);
      @(negedge clk);
    end
    RepReady = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    PCF       = pc_of(5, 3, 0);
    RepReady  = 1'b0;
    RepWord   = '0;
    PCSrcReg  = 2'b00;
    BranchOpE = 2'b00;

    // 1. Reset state
    #50;
    push_exp("reset miss", 32'd1);
    pop_cmp(32'(InstrMissF));
    push_exp("reset instr", 32'd0);
    pop_cmp(InstrF);
    push_exp("reset active", 32'd0);
    pop_cmp(32'(InstrCacheRepActive));
    #50;
    reset = 1'b0;

    // 2. Single refill into set 0, offset sweep
    PCF      = pc_of(100, 0, 0);
    RepReady = 1'b1;
    RepWord  = beat(0, 0, 0);
    check_active("t2 first beat", 1'b1);
    push_exp("t2 miss instr", 32'd0);
    pop_cmp(InstrF);
    @(negedge clk);
    beats(pc_of(100, 0, 0), 0, 0, 1, 8);
    check_active("t2 done", 1'b0);
    check_block("t2 sweep", 100, 0, 0, 0);

    // 3. Fill every way of every set, check each block, then reread all
    for (int i = 0; i < 32; i++) begin
      for (int n = 0; n < 4; n++) begin
        beats(pc_of(i * 8 + n * n * n, i, 0), 1, i, 0, 8);
        check_block("t3 fill", i * 8 + n * n * n, i, 1, i);
      end
    end
    for (int i = 0; i < 32; i++) begin
      for (int n = 0; n < 4; n++) begin
        check_block("t3 reread", i * 8 + n * n * n, i, 1, i);
      end
    end

    // 4. LRU replacement in set 5
    for (int n = 0; n < 4; n++) begin
      check_word("t4 touch", pc_of(40 + n * n * n, 5, 0), 1'b0, word_exp(1, 5, 0));
    end
    check_word("t4 new miss", pc_of(104, 5, 0), 1'b1, 32'd0);
    beats(pc_of(104, 5, 0), 1, 50, 0, 8);
    check_block("t4 new", 104, 5, 1, 50);
    check_word("t4 evicted", pc_of(40, 5, 0), 1'b1, 32'd0);
    for (int n = 1; n < 4; n++) begin
      check_word("t4 kept", pc_of(40 + n * n * n, 5, 4), 1'b0, word_exp(1, 5, 1));
    end

    // 5. Stalled refill
    beats(pc_of(200, 7, 0), 1, 51, 0, 4);
    for (int c = 0; c < 3; c++) begin
      check_active("t5 stall", 1'b1);
      push_exp("t5 stall miss", 32'd1);
      pop_cmp(32'(InstrMissF));
      @(negedge clk);
    end
    beats(pc_of(200, 7, 0), 1, 51, 4, 8);
    check_block("t5 block", 200, 7, 1, 51);

    // 6. Abort after 3 beats
    beats(pc_of(300, 9, 0), 1, 52, 0, 3);
    PCSrcReg = 2'b01;
    @(negedge clk);
    PCSrcReg = 2'b00;
    check_active("t6 aborted", 1'b0);
    check_word("t6 still miss", pc_of(300, 9, 0), 1'b1, 32'd0);
    beats(pc_of(300, 9, 0), 1, 52, 0, 8);
    check_block("t6 refill", 300, 9, 1, 52);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
